// File: rtl/ps2_key_ctrl_if.sv
// Signal bundle between the PS/2 pins, the key controller and the game core.
// The slave side is the controller; the master side drives the pins and consumes the key state.
interface ps2_key_ctrl_if;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic       BTN_CENTER;
  logic       BTN_UP;
  logic       BTN_DOWN;
  logic       BTN_LEFT;
  logic       BTN_RIGHT;
  logic       SCAN_VALID;
  logic [7:0] SCAN_CODE;
  logic       SCAN_EXT;
  logic       SCAN_BREAK;
  logic       FRAME_ERR;

  modport slave (
    input  PS2_CLK, PS2_DATA,
    output BTN_CENTER, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT,
    output SCAN_VALID, SCAN_CODE, SCAN_EXT, SCAN_BREAK, FRAME_ERR
  );

  modport master (
    output PS2_CLK, PS2_DATA,
    input  BTN_CENTER, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT,
    input  SCAN_VALID, SCAN_CODE, SCAN_EXT, SCAN_BREAK, FRAME_ERR
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame FSM with timeout,
// scan-code decoder and held-state for the five game buttons.
module ps2_key_ctrl #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic          CLK_25MHZ,
  input  logic          RESET_N,
  ps2_key_ctrl_if.slave bus
);

  localparam int FL_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_filt_clk;
  logic [FL_W-1:0] r_filt_cnt;
  logic            w_fall;

  state_t          r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_byte_stb;
  logic            r_frame_err;

  logic            r_ext, r_brk;
  logic            r_scan_valid, r_scan_ext, r_scan_brk;
  logic [7:0]      r_scan_code;
  logic            r_btn_c, r_btn_u, r_btn_d, r_btn_l, r_btn_r;

  // Synchronisers and clock filter; idle PS/2 lines are high, so they reset high.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1 <= bus.PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.PS2_DATA;
      r_dat_s2 <= r_dat_s1;
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FL_W'(FILTER_LEN - 1)) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // High in the cycle the filtered clock is about to go 1->0.
  assign w_fall = r_filt_clk && !r_clk_s2 && (r_filt_cnt == FL_W'(FILTER_LEN - 1));

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_byte_stb  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_stb  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        // An edge on the timeout terminal count takes priority over the timeout.
        r_to_cnt <= '0;
        unique case (r_state)
          S_IDLE: if (!r_dat_s2) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
          end
          S_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= S_STOP;
          end
          S_STOP: begin
            if (r_dat_s2 && (^{r_shift, r_par})) r_byte_stb  <= 1'b1;
            else                                 r_frame_err <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state == S_IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        r_to_cnt    <= '0;
        r_frame_err <= 1'b1;
        r_state     <= S_IDLE;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  // Decoder: r_shift holds the completed byte while r_byte_stb is high.
  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_scan_valid <= 1'b0;
      r_scan_code  <= '0;
      r_scan_ext   <= 1'b0;
      r_scan_brk   <= 1'b0;
      r_btn_c      <= 1'b0;
      r_btn_u      <= 1'b0;
      r_btn_d      <= 1'b0;
      r_btn_l      <= 1'b0;
      r_btn_r      <= 1'b0;
    end else begin
      r_scan_valid <= 1'b0;
      if (r_frame_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_byte_stb) begin
        case (r_shift)
          8'hE0: r_ext <= 1'b1;
          8'hF0: r_brk <= 1'b1;
          8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
          end
          default: begin
            r_scan_valid <= 1'b1;
            r_scan_code  <= r_shift;
            r_scan_ext   <= r_ext;
            r_scan_brk   <= r_brk;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            if (!r_ext && r_shift == 8'h29) r_btn_c <= !r_brk;
            if (r_ext) begin
              case (r_shift)
                8'h75:   r_btn_u <= !r_brk;
                8'h72:   r_btn_d <= !r_brk;
                8'h6B:   r_btn_l <= !r_brk;
                8'h74:   r_btn_r <= !r_brk;
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign bus.SCAN_VALID = r_scan_valid;
  assign bus.SCAN_CODE  = r_scan_code;
  assign bus.SCAN_EXT   = r_scan_ext;
  assign bus.SCAN_BREAK = r_scan_brk;
  assign bus.FRAME_ERR  = r_frame_err;
  assign bus.BTN_CENTER = r_btn_c;
  assign bus.BTN_UP     = r_btn_u;
  assign bus.BTN_DOWN   = r_btn_d;
  assign bus.BTN_LEFT   = r_btn_l;
  assign bus.BTN_RIGHT  = r_btn_r;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: drives PS/2 frames on the pins and checks decoded
// events, button state, frame errors, glitch rejection and asynchronous reset.
module tb_ps2_key_ctrl;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 400;
  localparam int HALF       = 20;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_valid  = 0;
  int   n_ferr   = 0;
  int   n_both   = 0;
  int   v0, e0;

  ps2_key_ctrl_if bus ();

  ps2_key_ctrl #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK_25MHZ (clk),
    .RESET_N   (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.SCAN_VALID) n_valid++;
      if (bus.FRAME_ERR)  n_ferr++;
      if (bus.SCAN_VALID && bus.FRAME_ERR) n_both++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] btns();
    return {bus.BTN_CENTER, bus.BTN_UP, bus.BTN_DOWN, bus.BTN_LEFT, bus.BTN_RIGHT};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits of start/8 data/parity/stop; bad_par flips the parity bit.
  task automatic ps2_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.PS2_DATA = bits[i];
      wait_cycles(HALF / 2);
      bus.PS2_CLK = 1'b0;
      wait_cycles(HALF);
      bus.PS2_CLK = 1'b1;
      wait_cycles(HALF / 2);
    end
    bus.PS2_DATA = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic send(input logic [7:0] b);
    ps2_frame(b, 1'b0, 11);
  endtask

  task automatic snap();
    v0 = n_valid;
    e0 = n_ferr;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.PS2_CLK  = 1'b1;
    bus.PS2_DATA = 1'b1;
    wait_cycles(3);
    check("reset_btns", {27'd0, btns()}, 32'd0);
    check("reset_scan", {21'd0, bus.SCAN_VALID, bus.SCAN_CODE, bus.SCAN_EXT, bus.SCAN_BREAK, bus.FRAME_ERR}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Space make then break
    snap();
    send(8'h29);
    check("space_make_valid", n_valid - v0, 1);
    check("space_make_scan", {bus.SCAN_CODE, bus.SCAN_EXT, bus.SCAN_BREAK}, {8'h29, 2'b00});
    check("space_make_btn", {27'd0, btns()}, 32'b10000);
    snap();
    send(8'hF0);
    check("f0_no_valid", n_valid - v0, 0);
    send(8'h29);
    check("space_brk_valid", n_valid - v0, 1);
    check("space_brk_scan", {bus.SCAN_CODE, bus.SCAN_EXT, bus.SCAN_BREAK}, {8'h29, 2'b01});
    check("space_brk_btn", {27'd0, btns()}, 32'd0);

    // Extended left arrow, and the non-extended keypad code
    send(8'hE0); send(8'h6B);
    check("left_make", {27'd0, btns()}, 32'b00010);
    check("left_make_ext", {bus.SCAN_CODE, bus.SCAN_EXT, bus.SCAN_BREAK}, {8'h6B, 2'b10});
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("left_break", {27'd0, btns()}, 32'd0);
    check("left_break_scan", {bus.SCAN_CODE, bus.SCAN_EXT, bus.SCAN_BREAK}, {8'h6B, 2'b11});
    send(8'hE0); send(8'h6B);
    snap();
    send(8'h6B);
    check("kp4_valid", n_valid - v0, 1);
    check("kp4_scan", {bus.SCAN_CODE, bus.SCAN_EXT, bus.SCAN_BREAK}, {8'h6B, 2'b00});
    check("kp4_left_held", {27'd0, btns()}, 32'b00010);
    snap();
    send(8'hE0); send(8'h6B);
    check("typematic_valid", n_valid - v0, 1);
    check("typematic_btn", {27'd0, btns()}, 32'b00010);
    send(8'hE0); send(8'hF0); send(8'h6B);

    // Parity error
    snap();
    ps2_frame(8'h29, 1'b1, 11);
    check("par_err_count", n_ferr - e0, 1);
    check("par_err_no_valid", n_valid - v0, 0);
    check("par_err_btn", {27'd0, btns()}, 32'd0);
    check("par_err_scan_held", {bus.SCAN_CODE, bus.SCAN_EXT, bus.SCAN_BREAK}, {8'h6B, 2'b11});
    send(8'h29);
    check("after_par_valid", n_valid - v0, 1);
    check("after_par_btn", {27'd0, btns()}, 32'b10000);
    send(8'hF0); send(8'h29);

    // Prefix followed by a frame error must not leak into the next event
    snap();
    send(8'hF0);
    ps2_frame(8'h11, 1'b1, 11);
    send(8'h29);
    check("err_clears_brk", {bus.SCAN_CODE, bus.SCAN_EXT, bus.SCAN_BREAK}, {8'h29, 2'b00});
    check("err_clears_brk_btn", {27'd0, btns()}, 32'b10000);
    send(8'hF0); send(8'h29);

    // Timeout after 4 data bits
    snap();
    ps2_frame(8'h75, 1'b0, 5);
    wait_cycles(TIMEOUT + 100);
    check("timeout_count", n_ferr - e0, 1);
    check("timeout_no_valid", n_valid - v0, 0);
    send(8'hE0); send(8'h75);
    check("up_after_timeout", {27'd0, btns()}, 32'b01000);

    // Short clock glitch while idle with data low
    snap();
    @(negedge clk);
    bus.PS2_DATA = 1'b0;
    bus.PS2_CLK  = 1'b0;
    wait_cycles(3);
    bus.PS2_CLK  = 1'b1;
    wait_cycles(5);
    bus.PS2_DATA = 1'b1;
    wait_cycles(30);
    check("glitch_no_pulses", (n_valid - v0) + (n_ferr - e0), 0);
    send(8'h74);
    check("glitch_then_frame", {bus.SCAN_CODE, bus.SCAN_EXT, bus.SCAN_BREAK}, {8'h74, 2'b00});
    check("glitch_btn", {27'd0, btns()}, 32'b01000);

    // Reset mid-frame while up is held
    ps2_frame(8'h72, 1'b0, 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_btns", {27'd0, btns()}, 32'd0);
    check("rst_scan", {21'd0, bus.SCAN_VALID, bus.SCAN_CODE, bus.SCAN_EXT, bus.SCAN_BREAK, bus.FRAME_ERR}, 32'd0);
    wait_cycles(4);
    rst_n = 1'b1;
    wait_cycles(5);
    snap();
    send(8'hE0); send(8'h72);
    check("down_after_rst", {27'd0, btns()}, 32'b00100);
    check("down_scan", {bus.SCAN_CODE, bus.SCAN_EXT, bus.SCAN_BREAK}, {8'h72, 2'b10});
    check("down_no_err", n_ferr - e0, 0);

    check("valid_err_overlap", n_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

PS/2 keyboard controller for the Space Invaders core. It receives raw `PS2_CLK`/`PS2_DATA` from the board pins and deserialises device-to-host frames. It decodes make, break and extended prefixes, and keeps held-state for the five game buttons. It sits between the board top level and `topEntity` and drives `BTN_CENTER/UP/DOWN/LEFT/RIGHT` in place of the tied-off constants.

## Interface
- `FILTER_LEN`, 8: number of consecutive identical synchronised samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 25000: idle cycles allowed between falling edges inside a frame (1 ms at 25 MHz). Must be ≥ 2.
- `CLK_25MHZ` in 1: the only clock. All logic is on its rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `PS2_CLK` in 1: raw PS/2 clock, asynchronous to `CLK_25MHZ`.
- `PS2_DATA` in 1: raw PS/2 data, asynchronous to `CLK_25MHZ`.
- `BTN_CENTER` out 1: Space held (code 0x29, not extended).
- `BTN_UP` out 1: Up arrow held (E0 75).
- `BTN_DOWN` out 1: Down arrow held (E0 72).
- `BTN_LEFT` out 1: Left arrow held (E0 6B).
- `BTN_RIGHT` out 1: Right arrow held (E0 74).
- `SCAN_VALID` out 1: one-cycle pulse when a complete key event is decoded.
- `SCAN_CODE` out 8: final code byte of the event. Held until the next event.
- `SCAN_EXT` out 1: the event was preceded by E0. Held with `SCAN_CODE`.
- `SCAN_BREAK` out 1: the event was preceded by F0. Held with `SCAN_CODE`.
- `FRAME_ERR` out 1: one-cycle pulse on a start, parity, stop or timeout error.

## Operation
- **Input conditioning:**
  - Two-flop synchroniser on each of `PS2_CLK` and `PS2_DATA`.
  - Filtered clock takes the synchronised clock level after `FILTER_LEN` consecutive equal samples. It resets to 1.
  - A falling edge is a filtered 1→0 transition. Data is sampled from the synchronised data at that edge.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP. Advances only on falling edges, except for timeout.
  - IDLE: data=0 → DATA with bit count 0. Data=1 → stay in IDLE, no error.
  - DATA: shift the bit in LSB-first. After bit 7 → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: data=1 and odd parity over the 8 data bits plus the parity bit → byte strobe. Otherwise `FRAME_ERR`. Either way → IDLE.
- **Timeout:**
  - The counter clears on every falling edge and in IDLE.
  - In a non-IDLE state, reaching `TIMEOUT_CYCLES-1` → `FRAME_ERR` and IDLE.
- **Decoder:** consumes byte strobes.
  - E0 sets the ext flag.
  - F0 sets the brk flag.
  - AA, FA, EE, FE, 00 and FF are ignored and clear both flags.
  - Any other byte: latch code/ext/brk into `SCAN_*`, pulse `SCAN_VALID`, clear both flags.
  - If the event matches a button mapping, that button is set on make (brk=0) and cleared on break (brk=1).
  - Non-matching events leave all buttons unchanged, including the non-extended keypad codes 75/72/6B/74.
- **Typematic repeat:** repeated make codes pulse `SCAN_VALID` each time. The button stays at 1.
- **`FRAME_ERR`:** clears the ext/brk flags. Button state and the `SCAN_*` registers are unchanged.

## Timing
- All outputs reset to 0 asynchronously when `RESET_N`=0. This includes the FSM (→ IDLE), counters, flags and the filtered clock (→ 1).
- Release is synchronous: the first active edge after `RESET_N` rises runs normally.
- Edge detect latency: 2 synchroniser cycles plus `FILTER_LEN` cycles after the raw pin falls.
- Byte strobe: asserted in the cycle after the STOP falling edge is detected.
- `SCAN_VALID`, `SCAN_*` updates and button updates: registered, one cycle after the byte strobe.
- `FRAME_ERR` is asserted:
  - one cycle after a bad STOP edge, or
  - in the cycle after the counter reaches `TIMEOUT_CYCLES-1`.
- A falling edge in the same cycle as the timeout terminal count: the edge wins and no error is raised.
- `SCAN_VALID` and `FRAME_ERR` are never asserted in the same cycle.
- Reset asserted mid-frame: the partial byte is discarded, and held buttons drop to 0 immediately.

## Test plan
- Frame 0x29 (parity 0) → one `SCAN_VALID`, `SCAN_CODE`=0x29, EXT=0, BREAK=0, `BTN_CENTER`=1. Then F0 and 0x29 → `BTN_CENTER`=0, one `SCAN_VALID` with BREAK=1. No pulse for F0 itself.
- E0 6B → `BTN_LEFT`=1. E0 F0 6B → `BTN_LEFT`=0. A plain 6B → `SCAN_VALID` with EXT=0, `BTN_LEFT` unchanged.
- 0x29 sent with parity bit 1 → exactly one `FRAME_ERR` pulse, no `SCAN_VALID`, buttons unchanged. The next good 0x29 decodes normally.
- Clock stops after 4 data bits for `TIMEOUT_CYCLES`+100 cycles → exactly one `FRAME_ERR`. The following E0 75 sets `BTN_UP`=1.
- 3-cycle low glitch on `PS2_CLK` while idle, with `PS2_DATA`=0 → no state change, no pulses.
- `BTN_UP`=1, then `RESET_N`=0 mid-frame → all outputs 0 in the same cycle. After release, a full E0 72 frame sets `BTN_DOWN`=1 only.
